mmu_walker_arbiter: RTL

- Shares one page-table walker (MMU) between the instruction TLB and the data TLB.
- Latches miss requests from each TLB and grants the walker to one requester at a time (round-robin or fixed priority).
- Forwards the walk to the walker, routes the PTE response or fault back to the owner, and propagates aborts.
- Sits between the itlb/dtlb miss ports and a single mmu instance.

---
 rtl/mmu_walker_arbiter_pkg.sv | 53 +++++
 rtl/mmu_arb_req_buffer.sv | 34 +++
 rtl/mmu_walker_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_walker_arbiter_pkg.sv
// Shared types for the itlb/dtlb page-table walker arbiter (package mmu_arb_types).
// Holds the FSM/requester enums, the captured walk request and the PTE permission bits.
package mmu_arb_types;

    localparam int VA_W  = 32;
    localparam int PPN_W = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef struct packed {
        logic [VA_W-1:0] vaddr;
        logic            rnw;
        logic            execute;
    } walk_req_t;

    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } pte_perms_t;

    // On a tie, fixed mode always favours the data side; otherwise alternate away from last_grant.
    function automatic requester_t pick_winner(
        input logic       cand_i,
        input logic       cand_d,
        input requester_t last_grant,
        input logic       fixed_prio
    );
        requester_t w_pick;
        if (cand_i && cand_d) begin
            if (fixed_prio) w_pick = REQ_D;
            else            w_pick = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else begin
            w_pick = cand_d ? REQ_D : REQ_I;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/mmu_arb_req_buffer.sv
// One-entry miss buffer for a single TLB port: pending flag plus captured walk request.
// Abort beats a same-cycle request; a request while pending leaves the captured data untouched.
module mmu_arb_req_buffer
    import mmu_arb_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_request,
    input  logic      i_abort,
    input  logic      i_clear,
    input  walk_req_t i_req,
    output logic      o_pending,
    output walk_req_t o_req
);

    logic      r_pending;
    walk_req_t r_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_abort || i_clear) begin
            r_pending <= 1'b0;
        end else if (i_request && !r_pending) begin
            r_pending <= 1'b1;
            r_req     <= i_req;
        end
    end

    assign o_pending = r_pending;
    assign o_req     = r_req;

endmodule

// File: rtl/mmu_walker_arbiter.sv
// Shares one page-table walker between the itlb and dtlb miss ports.
// Optional saturating grant/conflict counters are built when MMU_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | walker free; grants a pending port unless sfence_valid is high
// BUSY_I | walker owned by the itlb; completion/fault/abort routed to the i-side
// BUSY_D | walker owned by the dtlb; completion/fault/abort routed to the d-side
module mmu_walker_arbiter
    import mmu_arb_types::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int STAT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sfence_valid,

    input  logic              i_request,
    input  logic [VA_W-1:0]   i_virtual_address,
    input  logic              i_rnw,
    input  logic              i_execute,
    input  logic              i_abort,
    output logic              i_write_entry,
    output logic              i_is_fault,

    input  logic              d_request,
    input  logic [VA_W-1:0]   d_virtual_address,
    input  logic              d_rnw,
    input  logic              d_execute,
    input  logic              d_abort,
    output logic              d_write_entry,
    output logic              d_is_fault,

    output logic [PPN_W-1:0]  upper_physical_address,
    output pte_perms_t        perms,
    output logic              superpage,

    output logic              ptw_request,
    output logic [VA_W-1:0]   ptw_virtual_address,
    output logic              ptw_rnw,
    output logic              ptw_execute,
    output logic              ptw_abort,
    input  logic              ptw_write_entry,
    input  logic              ptw_is_fault,
    input  logic [PPN_W-1:0]  ptw_upper_physical_address,
    input  pte_perms_t        ptw_perms,
    input  logic              ptw_superpage,

    output logic [STAT_W-1:0] stat_i_grants,
    output logic [STAT_W-1:0] stat_d_grants,
    output logic [STAT_W-1:0] stat_conflicts
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    requester_t r_last_grant;
    requester_t w_winner;

    logic      w_pend_i, w_pend_d;
    logic      w_cand_i, w_cand_d;
    logic      w_grant;
    logic      w_walk_done;
    logic      w_done_i, w_done_d;
    walk_req_t w_in_i, w_in_d;
    walk_req_t w_req_i, w_req_d;
    walk_req_t w_sel;

    assign w_in_i = '{vaddr: i_virtual_address, rnw: i_rnw, execute: i_execute};
    assign w_in_d = '{vaddr: d_virtual_address, rnw: d_rnw, execute: d_execute};

    // Owner's pending stays set for the whole walk so its port ignores new requests meanwhile.
    assign w_walk_done = ptw_write_entry | ptw_is_fault;
    assign w_done_i    = (r_state == BUSY_I) & w_walk_done;
    assign w_done_d    = (r_state == BUSY_D) & w_walk_done;

    mmu_arb_req_buffer u_buf_i (
        .clk       (clk),
        .rst       (rst),
        .i_request (i_request),
        .i_abort   (i_abort),
        .i_clear   (w_done_i),
        .i_req     (w_in_i),
        .o_pending (w_pend_i),
        .o_req     (w_req_i)
    );

    mmu_arb_req_buffer u_buf_d (
        .clk       (clk),
        .rst       (rst),
        .i_request (d_request),
        .i_abort   (d_abort),
        .i_clear   (w_done_d),
        .i_req     (w_in_d),
        .o_pending (w_pend_d),
        .o_req     (w_req_d)
    );

    // A port aborting this very cycle is not eligible; its pending bit is about to clear.
    assign w_cand_i = w_pend_i & ~i_abort;
    assign w_cand_d = w_pend_d & ~d_abort;
    assign w_grant  = (r_state == IDLE) & ~sfence_valid & (w_cand_i | w_cand_d);
    assign w_winner = pick_winner(w_cand_i, w_cand_d, r_last_grant, FIXED_PRIORITY != 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_state_next = (w_winner == REQ_D) ? BUSY_D : BUSY_I;
            BUSY_I:  if (w_walk_done || i_abort) w_state_next = IDLE;
            BUSY_D:  if (w_walk_done || d_abort) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ptw_request   = 1'b0;
        ptw_abort     = 1'b0;
        w_sel         = '0;
        i_write_entry = 1'b0;
        i_is_fault    = 1'b0;
        d_write_entry = 1'b0;
        d_is_fault    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    ptw_request = 1'b1;
                    w_sel       = (w_winner == REQ_D) ? w_req_d : w_req_i;
                end
            end
            BUSY_I: begin
                w_sel         = w_req_i;
                i_write_entry = ptw_write_entry;
                i_is_fault    = ptw_is_fault;
                ptw_abort     = i_abort;
            end
            BUSY_D: begin
                w_sel         = w_req_d;
                d_write_entry = ptw_write_entry;
                d_is_fault    = ptw_is_fault;
                ptw_abort     = d_abort;
            end
            default: ;
        endcase
    end

    assign ptw_virtual_address = w_sel.vaddr;
    assign ptw_rnw             = w_sel.rnw;
    assign ptw_execute         = w_sel.execute;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_last_grant <= REQ_I;
        else if (w_grant) r_last_grant <= w_winner;
    end

    // The TLBs only consume these when their write_entry strobe is high.
    assign upper_physical_address = ptw_upper_physical_address;
    assign perms                  = ptw_perms;
    assign superpage              = ptw_superpage;

`ifdef MMU_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] r_stat_i, r_stat_d, r_stat_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_i <= '0;
            r_stat_d <= '0;
            r_stat_c <= '0;
        end else if (w_grant) begin
            if (w_winner == REQ_I && r_stat_i != STAT_MAX) r_stat_i <= r_stat_i + 1'b1;
            if (w_winner == REQ_D && r_stat_d != STAT_MAX) r_stat_d <= r_stat_d + 1'b1;
            if (w_cand_i && w_cand_d && r_stat_c != STAT_MAX) r_stat_c <= r_stat_c + 1'b1;
        end
    end

    assign stat_i_grants  = r_stat_i;
    assign stat_d_grants  = r_stat_d;
    assign stat_conflicts = r_stat_c;
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_conflicts = '0;
`endif

endmodule
